// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline-stage registers between IF/ID, ID/EX,
// EX/MEM and MEM/WB.
package pipe_pkg;

    // Stage fill level; the encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } stage_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam int          IF_ID_W   = 64;

    // Number of entries held in a given state.
    function automatic logic [1:0] occ_of(stage_state_t st);
        return st;
    endfunction

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Valid/ready handshake bundle for one pipeline stage: the upstream side,
// the downstream side and the fill-level status.
interface pipe_stage_skid_if #(
    parameter int DATA_W = 64
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occupancy;

    // The stage itself.
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, occupancy
    );

    // Whatever drives and drains the stage.
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, occupancy
    );
endinterface

// File: rtl/pipe_data_reg.sv
// Payload register with load enable and synchronous clear to the bubble value.
module pipe_data_reg #(
    parameter int              DATA_W     = 64,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = {DATA_W{1'b0}}
) (
    input  logic              Clk,
    input  logic              clr,
    input  logic              load,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    // Clear wins over load so a flush can never leave stale payload behind.
    // NOTE: non-blocking (<=) in clocked logic so every flop samples pre-edge values.
    // NOTE: the payload is cleared on reset (not left X) because out_data must read BUBBLE_VAL whenever the stage is empty.
    always_ff @(posedge Clk) begin
        if (clr)
            q <= BUBBLE_VAL;
        else if (load)
            q <= d;
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, stall, flush and an
// optional second (skid) entry that lets in_ready come straight from a flop.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int                DATA_W     = IF_ID_W,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = {DATA_W{1'b0}},
    parameter bit                SKID       = 1'b1
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Flush,
    pipe_stage_skid_if.slave   bus
);

    stage_state_t      state, state_n;
    logic              in_ready_w, out_valid_w;
    logic              ix, ox;
    logic              main_load, main_clr, main_sel_skid;
    logic              skid_load, skid_clr;
    logic [DATA_W-1:0] main_d, main_q, skid_q;

    assign out_valid_w = (state != ST_EMPTY);
    assign ix          = bus.in_valid && in_ready_w;
    assign ox          = out_valid_w && bus.out_ready;

    // State register; Reset dominates everything else.
    always_ff @(posedge Clk) begin
        if (Reset)
            state <= ST_EMPTY;
        else
            state <= state_n;
    end

    // Next state and register controls; Reset/Flush drop every held entry.
    // NOTE: every output gets a default first so no path leaves a latch.
    always_comb begin
        state_n       = state;
        main_load     = 1'b0;
        main_clr      = 1'b0;
        main_sel_skid = 1'b0;
        skid_load     = 1'b0;
        skid_clr      = 1'b0;
        if (Reset || Flush) begin
            state_n  = ST_EMPTY;
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (ix) begin
                        state_n   = ST_ONE;
                        main_load = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (ix && ox) begin
                        main_load = 1'b1;
                    end else if (ix) begin
                        state_n   = ST_FULL;
                        skid_load = 1'b1;
                    end else if (ox) begin
                        state_n  = ST_EMPTY;
                        main_clr = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (ox) begin
                        state_n       = ST_ONE;
                        main_load     = 1'b1;
                        main_sel_skid = 1'b1;
                        skid_clr      = 1'b1;
                    end
                end
                default: begin
                    state_n  = ST_EMPTY;
                    main_clr = 1'b1;
                    skid_clr = 1'b1;
                end
            endcase
        end
    end

    assign main_d = main_sel_skid ? skid_q : bus.in_data;

    pipe_data_reg #(.DATA_W(DATA_W), .BUBBLE_VAL(BUBBLE_VAL)) u_main (
        .Clk  (Clk),
        .clr  (main_clr),
        .load (main_load),
        .d    (main_d),
        .q    (main_q)
    );

    if (SKID) begin : g_skid
        logic in_ready_q;

        // Registered ready: accept unless the next state holds two entries.
        always_ff @(posedge Clk) begin
            if (Reset)
                in_ready_q <= 1'b1;
            else
                in_ready_q <= (state_n != ST_FULL);
        end

        assign in_ready_w = in_ready_q;

        pipe_data_reg #(.DATA_W(DATA_W), .BUBBLE_VAL(BUBBLE_VAL)) u_skid (
            .Clk  (Clk),
            .clr  (skid_clr),
            .load (skid_load),
            .d    (bus.in_data),
            .q    (skid_q)
        );
    end else begin : g_noskid
        logic unused_skid_ctl;

        // Single-entry stage: can take data if empty or draining this cycle.
        assign in_ready_w      = !out_valid_w || bus.out_ready;
        assign skid_q          = BUBBLE_VAL;
        assign unused_skid_ctl = skid_load | skid_clr;
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_w;
    assign bus.out_data  = main_q;
    assign bus.occupancy = occ_of(state);

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench: a queue model of each stage is checked every cycle,
// and directed scenarios add hand-computed literal expectations.
module tb_pipe_stage_skid;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst1, flush1, rst0, flush0;
    int   total = 0;
    int   bad   = 0;

    pipe_stage_skid_if #(.DATA_W(64)) if1 ();
    pipe_stage_skid_if #(.DATA_W(64)) if0 ();

    pipe_stage_skid #(.DATA_W(64), .BUBBLE_VAL(64'h0), .SKID(1'b1)) u_dut1 (
        .Clk   (clk),
        .Reset (rst1),
        .Flush (flush1),
        .bus   (if1.slave)
    );

    pipe_stage_skid #(.DATA_W(64), .BUBBLE_VAL(64'h0), .SKID(1'b0)) u_dut0 (
        .Clk   (clk),
        .Reset (rst0),
        .Flush (flush0),
        .bus   (if0.slave)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- queue models ----------------
    logic [63:0] q1[$];
    logic [63:0] q0[$];
    bit live1 = 0, live0 = 0;
    bit ix1, ox1, ix0, ox0;

    always @(posedge clk) begin
        if (rst1) begin
            q1.delete();
            live1 = 1;
        end else if (live1) begin
            ox1 = (q1.size() != 0) && if1.out_ready;
            ix1 = if1.in_valid && (q1.size() < 2);
            if (flush1) q1.delete();
            else begin
                if (ox1) void'(q1.pop_front());
                if (ix1) q1.push_back(if1.in_data);
            end
        end
        if (rst0) begin
            q0.delete();
            live0 = 1;
        end else if (live0) begin
            ox0 = (q0.size() != 0) && if0.out_ready;
            ix0 = if0.in_valid && ((q0.size() == 0) || if0.out_ready);
            if (flush0) q0.delete();
            else begin
                if (ox0) void'(q0.pop_front());
                if (ix0) q0.push_back(if0.in_data);
            end
        end
    end

    // Compare DUT outputs with the models away from the active edge.
    always @(negedge clk) begin
        if (live1) begin
            check("s1_valid", if1.out_valid, (q1.size() != 0));
            check("s1_data",  if1.out_data,  (q1.size() != 0) ? q1[0] : 64'h0);
            check("s1_occ",   if1.occupancy, q1.size());
            check("s1_ready", if1.in_ready,  (q1.size() < 2));
        end
        if (live0) begin
            check("s0_valid", if0.out_valid, (q0.size() != 0));
            check("s0_data",  if0.out_data,  (q0.size() != 0) ? q0[0] : 64'h0);
            check("s0_occ",   if0.occupancy, q0.size());
            check("s0_ready", if0.in_ready,  (q0.size() == 0) || if0.out_ready);
            check("s0_occ_le1", (if0.occupancy <= 2'd1), 1'b1);
        end
    end

    // ---------------- SKID=0 random traffic ----------------
    bit done0 = 0;
    initial begin
        logic [63:0] cnt;
        cnt = 64'h100;
        rst0 = 1'b1; flush0 = 1'b0;
        if0.in_valid = 1'b0; if0.in_data = '0; if0.out_ready = 1'b0;
        tick(); tick();
        rst0 = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if0.in_valid  = 1'($urandom_range(0, 1));
            if0.out_ready = 1'($urandom_range(0, 1));
            if0.in_data   = cnt;
            cnt++;
            tick();
        end
        if0.in_valid = 1'b0;
        done0 = 1;
    end

    // ---------------- SKID=1 directed scenarios ----------------
    initial begin
        rst1 = 1'b1; flush1 = 1'b0;
        if1.in_valid = 1'b0; if1.in_data = '0; if1.out_ready = 1'b0;

        // Reset for two cycles.
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_valid", if1.out_valid, 1'b0);
            check("rst_data",  if1.out_data,  64'h0);
            check("rst_occ",   if1.occupancy, 2'd0);
            check("rst_ready", if1.in_ready,  1'b1);
        end
        rst1 = 1'b0;

        // Steady flow: one-cycle latency, ready stays high.
        if1.out_ready = 1'b1;
        if1.in_valid  = 1'b1;
        if1.in_data   = 64'h0000_0004_2008_0005;
        tick();
        check("flow_p1",    if1.out_data, 64'h0000_0004_2008_0005);
        check("flow_ready", if1.in_ready, 1'b1);
        if1.in_data = 64'h0000_0008_2009_0007;
        tick();
        check("flow_p2",     if1.out_data, 64'h0000_0008_2009_0007);
        check("flow_ready2", if1.in_ready, 1'b1);
        if1.in_valid = 1'b0;
        tick();
        check("flow_empty", if1.out_valid, 1'b0);

        // Backpressure: A, B fill the stage, C waits upstream.
        if1.out_ready = 1'b0;
        if1.in_valid  = 1'b1;
        if1.in_data   = 64'hA;
        tick();
        check("bp_occ1", if1.occupancy, 2'd1);
        if1.in_data = 64'hB;
        tick();
        check("bp_occ2",   if1.occupancy, 2'd2);
        check("bp_ready0", if1.in_ready,  1'b0);
        check("bp_dataA",  if1.out_data,  64'hA);
        if1.in_data = 64'hC;
        tick(); tick();
        check("bp_stallA",   if1.out_data,  64'hA);
        check("bp_stallocc", if1.occupancy, 2'd2);
        if1.out_ready = 1'b1;
        tick();
        check("drain_B",    if1.out_data,  64'hB);
        check("drain_occ1", if1.occupancy, 2'd1);
        tick();
        check("drain_C",     if1.out_data,  64'hC);
        check("drain_occ1b", if1.occupancy, 2'd1);
        if1.in_valid = 1'b0;
        tick();
        check("drain_occ0", if1.occupancy, 2'd0);

        // Flush while FULL, offering D at the same time.
        if1.out_ready = 1'b0;
        if1.in_valid  = 1'b1;
        if1.in_data   = 64'h11;
        tick();
        if1.in_data = 64'h12;
        tick();
        check("fl_full", if1.occupancy, 2'd2);
        flush1 = 1'b1;
        if1.in_data = 64'hD;
        tick();
        flush1 = 1'b0;
        if1.in_valid = 1'b0;
        check("fl_valid", if1.out_valid, 1'b0);
        check("fl_data",  if1.out_data,  64'h0);
        check("fl_occ",   if1.occupancy, 2'd0);
        check("fl_ready", if1.in_ready,  1'b1);
        if1.out_ready = 1'b1;
        tick(); tick();
        check("fl_no_D", if1.out_valid, 1'b0);

        // Flush in ONE with a simultaneous accepted input: that input is dropped.
        if1.out_ready = 1'b0;
        if1.in_valid  = 1'b1;
        if1.in_data   = 64'h21;
        tick();
        flush1 = 1'b1;
        if1.in_data = 64'hD2;
        tick();
        flush1 = 1'b0;
        if1.in_valid = 1'b0;
        check("fl1_occ", if1.occupancy, 2'd0);
        check("fl1_data", if1.out_data, 64'h0);

        // 100 back-to-back random transfers: occupancy settles at one.
        if1.out_ready = 1'b1;
        if1.in_valid  = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if1.in_data = {$urandom, $urandom};
            tick();
            check("b2b_occ", if1.occupancy, 2'd1);
        end
        if1.in_valid = 1'b0;
        tick();
        check("b2b_end", if1.occupancy, 2'd0);

        // Reset mid-stall with both entries held.
        if1.out_ready = 1'b0;
        if1.in_valid  = 1'b1;
        if1.in_data   = 64'h31;
        tick();
        if1.in_data = 64'h32;
        tick();
        check("rs_full", if1.occupancy, 2'd2);
        if1.in_valid = 1'b0;
        rst1 = 1'b1;
        tick();
        rst1 = 1'b0;
        check("rs_occ",   if1.occupancy, 2'd0);
        check("rs_ready", if1.in_ready,  1'b1);
        check("rs_valid", if1.out_valid, 1'b0);
        if1.out_ready = 1'b1;
        if1.in_valid  = 1'b1;
        if1.in_data   = 64'hE;
        tick();
        if1.in_valid = 1'b0;
        check("rs_E", if1.out_data, 64'hE);
        tick();
        check("rs_done", if1.out_valid, 1'b0);

        // Wait for the SKID=0 traffic, with a bounded budget.
        for (int i = 0; i < 3000 && !done0; i++) tick();
        check("s0_finished", done0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
